// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - row-scanning matrix keypad controller with debounce and event handshake
module keypad_scanner #(
    parameter  int N_ROWS   = 4,
    parameter  int N_COLS   = 3,
    parameter  int SCAN_DIV = 1000,
    parameter  int DEBOUNCE = 4,
    localparam int CODE_W   = $clog2(N_ROWS * N_COLS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_COLS-1:0] cols,
    output logic [N_ROWS-1:0] rows,
    input  logic              ack,
    output logic              valid,
    output logic [CODE_W-1:0] data,
    output logic              press,
    output logic              overflow
);

    localparam int ROW_W = $clog2(N_ROWS);
    localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        DEB_DN = 2'd1,
        HELD   = 2'd2,
        DEB_UP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [DIV_W-1:0]    dwell_q, dwell_d;
    logic [DEB_W-1:0]    deb_q, deb_d;
    logic [N_COLS-1:0]   col_q, col_d;
    logic                valid_q, valid_d;
    logic [CODE_W-1:0]   data_q, data_d;
    logic                ovf_q, ovf_d;

    logic                sample;
    logic                col_hit;
    logic                confirm;
    logic                deb_done;
    logic [DEB_W-1:0]    deb_inc;
    logic [ROW_W-1:0]    row_next;
    logic [N_COLS-1:0]   lowest;
    logic [COL_W-1:0]    col_idx;
    logic [CODE_W-1:0]   code;

    assign sample   = (dwell_q == DIV_W'(SCAN_DIV - 1));
    assign dwell_d  = sample ? '0 : dwell_q + DIV_W'(1);
    assign col_hit  = |(cols & col_q);
    assign row_next = (row_q == ROW_W'(N_ROWS - 1)) ? '0 : row_q + ROW_W'(1);
    // Two's-complement trick isolates the lowest set column.
    assign lowest   = cols & (~cols + N_COLS'(1));
    assign deb_inc  = deb_q + DEB_W'(1);
    assign deb_done = (deb_inc == DEB_W'(DEBOUNCE));

    always_comb begin
        col_idx = '0;
        for (int i = 0; i < N_COLS; i++) begin
            if (col_d[i]) col_idx = COL_W'(i);
        end
        code = CODE_W'(int'(row_q) * N_COLS + int'(col_idx));
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        deb_d   = deb_q;
        col_d   = col_q;
        confirm = 1'b0;
        case (state_q)
            SCAN: begin
                if (sample) begin
                    if (cols == '0) begin
                        row_d = row_next;
                    end else begin
                        col_d = lowest;
                        deb_d = DEB_W'(1);
                        if (DEBOUNCE == 1) begin
                            state_d = HELD;
                            deb_d   = '0;
                            confirm = 1'b1;
                        end else begin
                            state_d = DEB_DN;
                        end
                    end
                end
            end
            DEB_DN: begin
                if (sample) begin
                    if (col_hit) begin
                        deb_d = deb_inc;
                        if (deb_done) begin
                            state_d = HELD;
                            deb_d   = '0;
                            confirm = 1'b1;
                        end
                    end else begin
                        state_d = SCAN;
                        row_d   = row_next;
                        deb_d   = '0;
                    end
                end
            end
            HELD: begin
                // Only the latched column matters here; other keys never roll over.
                if (sample && !col_hit) begin
                    if (DEBOUNCE == 1) begin
                        state_d = SCAN;
                        row_d   = row_next;
                        deb_d   = '0;
                    end else begin
                        state_d = DEB_UP;
                        deb_d   = DEB_W'(1);
                    end
                end
            end
            DEB_UP: begin
                if (sample) begin
                    if (!col_hit) begin
                        deb_d = deb_inc;
                        if (deb_done) begin
                            state_d = SCAN;
                            row_d   = row_next;
                            deb_d   = '0;
                        end
                    end else begin
                        state_d = HELD;
                        deb_d   = '0;
                    end
                end
            end
            default: begin
                state_d = SCAN;
                deb_d   = '0;
            end
        endcase
    end

    // A same-cycle ack frees the slot, so a new confirm may overwrite it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        if (valid_q && ack) valid_d = 1'b0;
        if (confirm) begin
            if (!valid_q || ack) begin
                valid_d = 1'b1;
                data_d  = code;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= SCAN;
            row_q   <= '0;
            dwell_q <= '0;
            deb_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            dwell_q <= dwell_d;
            deb_q   <= deb_d;
            col_q   <= col_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rows     = N_ROWS'(1) << row_q;
    assign valid    = valid_q;
    assign data     = data_q;
    assign press    = (state_q == HELD) || (state_q == DEB_UP);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed and randomized checks of keypad_scanner against a key-level model
module tb_keypad_scanner;

    localparam int N_ROWS   = 4;
    localparam int N_COLS   = 3;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;

    localparam int M_SCAN = 0;
    localparam int M_CONF = 1;
    localparam int M_HELD = 2;
    localparam int M_REL  = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        ack = 1'b0;
    logic [2:0]  cols = '0;
    logic [3:0]  rows;
    logic        valid;
    logic [3:0]  data;
    logic        press;
    logic        overflow;
    logic [10:0] obs;

    int checks = 0;
    int errors = 0;

    logic [2:0] keys [N_ROWS];

    typedef struct {
        int row;
        int mode;
        int col;
        int streak;
        int tick;
        int valid;
        int data;
        int ovf;
        int confirm;
    } mstate_t;

    mstate_t m;

    keypad_scanner #(
        .N_ROWS  (N_ROWS),
        .N_COLS  (N_COLS),
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .cols    (cols),
        .rows    (rows),
        .ack     (ack),
        .valid   (valid),
        .data    (data),
        .press   (press),
        .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    assign obs = {rows, valid, data, press, overflow};

    function automatic int lowest_col(logic [2:0] c);
        for (int i = 0; i < N_COLS; i++) if (c[i]) return i;
        return 0;
    endfunction

    // Key-level behaviour: one decision per scan sample, events queued in a single slot.
    function automatic mstate_t model_next(mstate_t s, logic rst, logic [2:0] c, logic a);
        mstate_t n;
        logic    smp;
        n = s;
        n.confirm = 0;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        smp    = (s.tick == SCAN_DIV - 1);
        n.tick = (s.tick + 1) % SCAN_DIV;
        if (s.valid != 0 && a) n.valid = 0;
        if (smp) begin
            if (s.mode == M_SCAN) begin
                if (c == 3'b000) n.row = (s.row + 1) % N_ROWS;
                else begin
                    n.col = lowest_col(c);
                    n.streak = 1;
                    if (DEBOUNCE == 1) begin n.mode = M_HELD; n.confirm = 1; end
                    else n.mode = M_CONF;
                end
            end else if (s.mode == M_CONF) begin
                if (c[s.col]) begin
                    n.streak = s.streak + 1;
                    if (n.streak == DEBOUNCE) begin n.mode = M_HELD; n.confirm = 1; end
                end else begin
                    n.mode = M_SCAN;
                    n.row = (s.row + 1) % N_ROWS;
                end
            end else if (s.mode == M_HELD) begin
                if (!c[s.col]) begin
                    if (DEBOUNCE == 1) begin n.mode = M_SCAN; n.row = (s.row + 1) % N_ROWS; end
                    else begin n.mode = M_REL; n.streak = 1; end
                end
            end else begin
                if (!c[s.col]) begin
                    n.streak = s.streak + 1;
                    if (n.streak == DEBOUNCE) begin n.mode = M_SCAN; n.row = (s.row + 1) % N_ROWS; end
                end else n.mode = M_HELD;
            end
        end
        if (n.confirm != 0) begin
            if (s.valid == 0 || a) begin
                n.valid = 1;
                n.data = s.row * N_COLS + n.col;
            end else n.ovf = 1;
        end
        return n;
    endfunction

    function automatic logic [10:0] exp_vec(mstate_t s);
        logic [3:0] r;
        r = 4'b0001 << s.row;
        return {r, 1'(s.valid), 4'(s.data), (s.mode == M_HELD || s.mode == M_REL), 1'(s.ovf)};
    endfunction

    task automatic drive_cols();
        logic [2:0] c;
        c = '0;
        for (int r = 0; r < N_ROWS; r++) if (rows[r] === 1'b1) c |= keys[r];
        cols = c;
    endtask

    task automatic step();
        m = model_next(m, RST, cols, ack);
        @(posedge CLK);
        #1;
        drive_cols();
    endtask

    task automatic set_key(int r, int c, logic v);
        keys[r][c] = v;
        drive_cols();
    endtask

    task automatic clear_keys();
        for (int r = 0; r < N_ROWS; r++) keys[r] = '0;
        drive_cols();
    endtask

    task automatic do_reset();
        ack = 1'b0;
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    task automatic wait_mode(int md, string what);
        int n;
        n = 0;
        while (m.mode != md && n < 400) begin step(); n++; end
        if (m.mode != md) begin
            checks++;
            errors++;
            $display("FAIL %s: timed out after %0d cycles waiting for key state %0d", what, n, md);
        end
    endtask

    task automatic run_samples(int count);
        logic s;
        for (int i = 0; i < count; i++) begin
            do begin
                s = (m.tick == SCAN_DIV - 1);
                step();
            end while (!s);
        end
    endtask

    task automatic test_reset();
        cols = 3'b101;
        ack = 1'b1;
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        ack = 1'b0;
        clear_keys();
        checks++;
        if (obs !== 11'b0001_0_0000_0_0) begin
            errors++; $display("FAIL reset_state: got %b want %b", obs, 11'b0001_0_0000_0_0);
        end
        checks++;
        if (obs !== exp_vec(m)) begin
            errors++; $display("FAIL reset_model: got %b want %b", obs, exp_vec(m));
        end
    endtask

    task automatic test_idle_scan();
        logic [3:0] want;
        clear_keys();
        do_reset();
        for (int k = 0; k <= 32; k++) begin
            want = 4'b0001 << ((k / SCAN_DIV) % N_ROWS);
            checks++;
            if (rows !== want || valid !== 1'b0 || press !== 1'b0) begin
                errors++;
                $display("FAIL idle_scan k=%0d: rows=%b valid=%b press=%b want rows=%b valid=0 press=0",
                         k, rows, valid, press, want);
            end
            step();
        end
    endtask

    task automatic test_single_press();
        clear_keys();
        do_reset();
        set_key(2, 1, 1'b1);
        wait_mode(M_HELD, "single_press_confirm");
        checks++;
        if ({rows, press, valid, data} !== {4'b0100, 1'b1, 1'b1, 4'd7}) begin
            errors++;
            $display("FAIL single_press: rows=%b press=%b valid=%b data=%0d want rows=0100 press=1 valid=1 data=7",
                     rows, press, valid, data);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0 || rows !== 4'b0100) begin
            errors++; $display("FAIL single_press_ack: valid=%b rows=%b want valid=0 rows=0100", valid, rows);
        end
        set_key(2, 1, 1'b0);
        wait_mode(M_SCAN, "single_press_release");
        checks++;
        if (obs !== exp_vec(m) || press !== 1'b0) begin
            errors++; $display("FAIL single_press_release: got %b want %b", obs, exp_vec(m));
        end
    endtask

    task automatic test_glitch();
        int n;
        clear_keys();
        do_reset();
        n = 0;
        while (m.row != 2 && n < 100) begin step(); n++; end
        set_key(2, 1, 1'b1);
        wait_mode(M_CONF, "glitch_latch");
        set_key(2, 1, 1'b0);
        run_samples(1);
        checks++;
        if ({rows, valid, press} !== {4'b1000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL glitch: rows=%b valid=%b press=%b want rows=1000 valid=0 press=0",
                               rows, valid, press);
        end
    endtask

    task automatic test_overflow();
        int n;
        mstate_t pk;
        clear_keys();
        do_reset();
        set_key(0, 2, 1'b1);
        wait_mode(M_HELD, "ovf_first");
        checks++;
        if ({valid, data} !== {1'b1, 4'd2}) begin
            errors++; $display("FAIL ovf_first: valid=%b data=%0d want valid=1 data=2", valid, data);
        end
        set_key(0, 2, 1'b0);
        wait_mode(M_SCAN, "ovf_release");
        set_key(3, 0, 1'b1);
        wait_mode(M_HELD, "ovf_second");
        checks++;
        if ({valid, data, overflow} !== {1'b1, 4'd2, 1'b1}) begin
            errors++; $display("FAIL ovf_lost: valid=%b data=%0d overflow=%b want valid=1 data=2 overflow=1",
                               valid, data, overflow);
        end
        checks++;
        if (obs !== exp_vec(m)) begin
            errors++; $display("FAIL ovf_model: got %b want %b", obs, exp_vec(m));
        end

        clear_keys();
        do_reset();
        set_key(0, 2, 1'b1);
        wait_mode(M_HELD, "ack_first");
        set_key(0, 2, 1'b0);
        wait_mode(M_SCAN, "ack_release");
        set_key(3, 0, 1'b1);
        n = 0;
        while (m.mode != M_HELD && n < 400) begin
            pk = model_next(m, 1'b0, cols, 1'b0);
            ack = (pk.confirm != 0);
            step();
            ack = 1'b0;
            n++;
        end
        checks++;
        if ({valid, data, overflow} !== {1'b1, 4'd9, 1'b0}) begin
            errors++; $display("FAIL ovf_same_cycle_ack: valid=%b data=%0d overflow=%b want valid=1 data=9 overflow=0",
                               valid, data, overflow);
        end
    endtask

    task automatic test_rollover_bounce();
        clear_keys();
        do_reset();
        set_key(1, 0, 1'b1);
        set_key(1, 2, 1'b1);
        wait_mode(M_HELD, "rollover_confirm");
        checks++;
        if ({valid, data, press} !== {1'b1, 4'd3, 1'b1}) begin
            errors++; $display("FAIL lowest_col: valid=%b data=%0d press=%b want valid=1 data=3 press=1",
                               valid, data, press);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        set_key(1, 0, 1'b0);
        run_samples(2);
        checks++;
        if (press !== 1'b1) begin
            errors++; $display("FAIL release_bounce_mid: press=%b want 1", press);
        end
        set_key(1, 0, 1'b1);
        run_samples(1);
        for (int i = 0; i < 12; i++) step();
        checks++;
        if ({press, valid, overflow, rows} !== {1'b1, 1'b0, 1'b0, 4'b0010}) begin
            errors++; $display("FAIL release_bounce: press=%b valid=%b overflow=%b rows=%b want 1 0 0 0010",
                               press, valid, overflow, rows);
        end
    endtask

    task automatic test_reset_held();
        clear_keys();
        do_reset();
        set_key(0, 1, 1'b1);
        wait_mode(M_HELD, "reset_held_confirm");
        RST = 1'b1;
        step();
        RST = 1'b0;
        checks++;
        if (obs !== 11'b0001_0_0000_0_0) begin
            errors++; $display("FAIL reset_held: got %b want %b", obs, 11'b0001_0_0000_0_0);
        end
        set_key(0, 1, 1'b0);
        set_key(2, 2, 1'b1);
        wait_mode(M_CONF, "reset_deb_latch");
        RST = 1'b1;
        step();
        RST = 1'b0;
        clear_keys();
        for (int i = 0; i < 40; i++) step();
        checks++;
        if ({valid, press, overflow} !== 3'b000) begin
            errors++; $display("FAIL reset_debounce: valid=%b press=%b overflow=%b want 000", valid, press, overflow);
        end
    endtask

    task automatic test_random();
        int r1, r2;
        for (int t = 0; t < 4; t++) begin
            clear_keys();
            do_reset();
            for (int k = 0; k < 600; k++) begin
                if ($urandom_range(0, 39) == 0) begin
                    for (int r = 0; r < N_ROWS; r++) keys[r] = '0;
                    r1 = $urandom_range(0, 9);
                    if (r1 >= 4) keys[$urandom_range(0, N_ROWS - 1)][$urandom_range(0, N_COLS - 1)] = 1'b1;
                    if (r1 == 9) begin
                        r2 = $urandom_range(0, N_ROWS - 1);
                        keys[r2][$urandom_range(0, N_COLS - 1)] = 1'b1;
                    end
                    drive_cols();
                end
                ack = ($urandom_range(0, 3) == 0);
                RST = ($urandom_range(0, 499) == 0);
                step();
                checks++;
                if (obs !== exp_vec(m)) begin
                    errors++;
                    if (errors < 20)
                        $display("FAIL random t=%0d k=%0d: {rows,valid,data,press,ovf} got %b want %b",
                                 t, k, obs, exp_vec(m));
                end
            end
            RST = 1'b0;
            ack = 1'b0;
        end
    endtask

    initial begin
        m = '{default: 0};
        for (int r = 0; r < N_ROWS; r++) keys[r] = '0;
        test_reset();
        test_idle_scan();
        test_single_press();
        test_glitch();
        test_overflow();
        test_rollover_bounce();
        test_reset_held();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
